// File: rtl/shot_clock_monitor.sv
// Shot-clock consumer: buzzer, low-time warning LED,
// per-team violation counters and leader tracking.
module shot_clock_monitor #(
  parameter int BUZZ_SECS = 3,
  parameter int WARN_AT   = 5
) (
  input  logic       clk_1Hz,
  input  logic       rst,
  input  logic [5:0] shot_clock,
  input  logic       team_a_poss,
  input  logic       team_b_poss,
  input  logic [7:0] score_a,
  input  logic [7:0] score_b,
  output logic       buzzer,
  output logic       warn_led,
  output logic [3:0] viol_a,
  output logic [3:0] viol_b,
  output logic       poss_owner,
  output logic [1:0] lead,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    WARN = 3'd2,
    BUZZ = 3'd3,
    HOLD = 3'd4
  } st_t;

  localparam logic [5:0] WARN_V = 6'(WARN_AT);
  localparam logic [2:0] BUZZ_V = 3'(BUZZ_SECS);

  st_t        st;
  logic [2:0] buzz_cnt;
  logic       any_poss;
  logic       at_zero;
  logic       low_time;

  assign any_poss = team_a_poss | team_b_poss;
  assign at_zero  = (shot_clock == 6'd0);
  assign low_time = (shot_clock <= WARN_V);
  assign state    = st;

  function automatic logic [3:0] sat_inc(
    input logic [3:0] v
  );
    return (v == 4'd15) ? v : v + 4'd1;
  endfunction

  always_ff @(posedge clk_1Hz or posedge rst) begin
    if (rst) begin
      st         <= IDLE;
      buzz_cnt   <= 3'd0;
      buzzer     <= 1'b0;
      warn_led   <= 1'b0;
      viol_a     <= 4'd0;
      viol_b     <= 4'd0;
      poss_owner <= 1'b0;
      lead       <= 2'b00;
    end else begin
      unique case (1'b1)
        (score_a > score_b): lead <= 2'b01;
        (score_a < score_b): lead <= 2'b10;
        default:             lead <= 2'b00;
      endcase

      unique case (st)
        IDLE: begin
          if (any_poss) begin
            st         <= RUN;
            poss_owner <= ~team_a_poss;
          end
        end

        RUN, WARN: begin
          if (!any_poss) begin
            st       <= IDLE;
            warn_led <= 1'b0;
          end else if (at_zero) begin
            st       <= BUZZ;
            buzzer   <= 1'b1;
            warn_led <= 1'b0;
            buzz_cnt <= 3'd1;
            if (poss_owner)
              viol_b <= sat_inc(viol_b);
            else
              viol_a <= sat_inc(viol_a);
          end else if (low_time) begin
            st <= WARN;
            // LED lights on entry, then blinks
            warn_led <= (st == WARN) ? ~warn_led : 1'b1;
          end else begin
            st       <= RUN;
            warn_led <= 1'b0;
          end
        end

        BUZZ: begin
          if (buzz_cnt == BUZZ_V) begin
            st       <= HOLD;
            buzzer   <= 1'b0;
            buzz_cnt <= 3'd0;
          end else begin
            buzz_cnt <= buzz_cnt + 3'd1;
          end
        end

        HOLD: begin
          if (!any_poss) begin
            st <= IDLE;
          end else if (!at_zero) begin
            st         <= RUN;
            poss_owner <= ~team_a_poss;
          end
        end

        default: begin
          st       <= IDLE;
          buzzer   <= 1'b0;
          warn_led <= 1'b0;
          buzz_cnt <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shot_clock_monitor.sv
// Directed + random bench for shot_clock_monitor,
// checked against a behavioural game model.
module tb_shot_clock_monitor;

  localparam int BUZZ_SECS = 3;
  localparam int WARN_AT   = 5;

  logic       clk_1Hz = 1'b0;
  logic       rst;
  logic [5:0] shot_clock;
  logic       team_a_poss;
  logic       team_b_poss;
  logic [7:0] score_a;
  logic [7:0] score_b;
  logic       buzzer;
  logic       warn_led;
  logic [3:0] viol_a;
  logic [3:0] viol_b;
  logic       poss_owner;
  logic [1:0] lead;
  logic [2:0] state;

  int vectors = 0;
  int miscompares = 0;

  shot_clock_monitor #(
    .BUZZ_SECS(BUZZ_SECS),
    .WARN_AT  (WARN_AT)
  ) dut (
    .clk_1Hz   (clk_1Hz),
    .rst       (rst),
    .shot_clock(shot_clock),
    .team_a_poss(team_a_poss),
    .team_b_poss(team_b_poss),
    .score_a   (score_a),
    .score_b   (score_b),
    .buzzer    (buzzer),
    .warn_led  (warn_led),
    .viol_a    (viol_a),
    .viol_b    (viol_b),
    .poss_owner(poss_owner),
    .lead      (lead),
    .state     (state)
  );

  always #5 clk_1Hz = ~clk_1Hz;

  // Model: mode names as plain ints 0..4
  int m_mode;
  int m_owner;
  int m_viol[2];
  int m_buzz_left;
  int m_warn_cycles;
  int m_lead;

  task automatic model_reset();
    m_mode = 0;
    m_owner = 0;
    m_viol[0] = 0;
    m_viol[1] = 0;
    m_buzz_left = 0;
    m_warn_cycles = 0;
    m_lead = 0;
  endtask

  task automatic model_edge();
    bit any;
    int sc;
    sc = int'(shot_clock);
    any = team_a_poss || team_b_poss;
    if (score_a > score_b) m_lead = 1;
    else if (score_b > score_a) m_lead = 2;
    else m_lead = 0;
    case (m_mode)
      0: if (any) begin
        m_mode = 1;
        m_owner = team_a_poss ? 0 : 1;
      end
      1, 2: begin
        if (!any) m_mode = 0;
        else if (sc == 0) begin
          m_mode = 3;
          m_buzz_left = BUZZ_SECS;
          if (m_viol[m_owner] < 15)
            m_viol[m_owner] += 1;
        end else if (sc <= WARN_AT) begin
          if (m_mode == 1) m_warn_cycles = 0;
          else m_warn_cycles += 1;
          m_mode = 2;
        end else m_mode = 1;
      end
      3: begin
        m_buzz_left -= 1;
        if (m_buzz_left == 0) m_mode = 4;
      end
      default: begin
        if (!any) m_mode = 0;
        else if (sc != 0) begin
          m_mode = 1;
          m_owner = team_a_poss ? 0 : 1;
        end
      end
    endcase
  endtask

  task automatic check(
    input string      tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit exp_led;
    exp_led = (m_mode == 2) && (m_warn_cycles % 2 == 0);
    check("state", 8'(state), 8'(m_mode));
    check("buzzer", 8'(buzzer), 8'(m_mode == 3));
    check("warn_led", 8'(warn_led), 8'(exp_led));
    check("viol_a", 8'(viol_a), 8'(m_viol[0]));
    check("viol_b", 8'(viol_b), 8'(m_viol[1]));
    check("poss_owner", 8'(poss_owner), 8'(m_owner));
    check("lead", 8'(lead), 8'(m_lead));
  endtask

  task automatic step(
    input int sc,
    input bit a,
    input bit b
  );
    shot_clock = 6'(sc);
    team_a_poss = a;
    team_b_poss = b;
    @(posedge clk_1Hz);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic violation(input bit a, input bit b);
    step(10, a, b);
    step(0, a, b);
    for (int k = 0; k < BUZZ_SECS; k++)
      step(0, a, b);
  endtask

  initial begin
    rst = 1'b1;
    shot_clock = 6'd24;
    team_a_poss = 1'b0;
    team_b_poss = 1'b0;
    score_a = 8'd0;
    score_b = 8'd0;
    model_reset();
    #2;
    check_all();
    @(negedge clk_1Hz);
    rst = 1'b0;

    // full countdown, team A
    for (int s = 24; s >= 0; s--) begin
      step(s, 1, 0);
      if (s == 5) check("warn_entry", 8'(state), 8'd2);
      if (s == 0) check("buzz_entry", 8'(buzzer), 8'd1);
    end
    for (int k = 0; k < BUZZ_SECS; k++)
      step(0, 1, 0);
    check("hold_after", 8'(state), 8'd4);
    check("viol_a_one", 8'(viol_a), 8'd1);

    // reload during WARN, team B
    step(10, 0, 0);
    step(10, 0, 1);
    step(4, 0, 1);
    step(24, 0, 1);
    check("reload_run", 8'(state), 8'd1);
    check("reload_led", 8'(warn_led), 8'd0);

    // possession release in WARN
    step(3, 0, 1);
    step(3, 0, 0);
    check("release_idle", 8'(state), 8'd0);

    // saturation, team B
    for (int i = 0; i < 17; i++)
      violation(0, 1);
    check("viol_b_sat", 8'(viol_b), 8'd15);

    // leader tracking
    score_a = 8'd10; score_b = 8'd10;
    step(10, 0, 0);
    check("lead_tie", 8'(lead), 8'd0);
    score_a = 8'd12;
    step(10, 0, 0);
    check("lead_a", 8'(lead), 8'd1);
    score_b = 8'd15;
    step(10, 0, 0);
    check("lead_b", 8'(lead), 8'd2);

    // both switches high -> owner A
    step(20, 1, 1);
    check("both_owner", 8'(poss_owner), 8'd0);
    step(0, 1, 1);
    check("both_viol", 8'(viol_a), 8'd2);
    for (int k = 0; k < BUZZ_SECS; k++)
      step(0, 1, 1);

    // third A violation, reset mid-BUZZ
    step(10, 1, 0);
    step(0, 1, 0);
    check("pre_rst_viol", 8'(viol_a), 8'd3);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    @(negedge clk_1Hz);
    rst = 1'b0;

    // random play
    for (int i = 0; i < 400; i++) begin
      score_a = 8'($urandom_range(0, 120));
      score_b = ($urandom_range(0, 3) == 0)
              ? score_a : 8'($urandom_range(0, 120));
      step($urandom_range(0, 3) == 0 ?
             $urandom_range(0, 6) : $urandom_range(0, 24),
           $urandom_range(0, 7) != 0,
           $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
